// File: rtl/apb_request_arbiter.sv
// apb_request_arbiter
// Round-robin arbiter that lets several command sources share one APB master.
// Each source holds a request until it receives a one-cycle response pulse.
// The arbiter grants one source, issues a single start pulse, waits for the
// master's done, and then returns the read data to the granted source.
module apb_request_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*32-1:0] req_addr,
    input  logic [NUM_REQ*32-1:0] req_wdata,
    input  logic [NUM_REQ-1:0]   req_write,
    output logic [NUM_REQ-1:0]   resp_valid,
    output logic [31:0]          resp_rdata,
    output logic                 busy,
    output logic [ID_W-1:0]      grant_id,
    output logic [31:0]          m_addr,
    output logic [31:0]          m_wdata,
    output logic                 m_write_en,
    output logic                 m_start,
    input  logic                 m_done,
    input  logic [31:0]          m_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ID_W-1:0]   last_grant_q;
    logic [ID_W-1:0]   win_id;
    logic              win_found;
    logic              any_req;
    logic [31:0]       addr_arr  [NUM_REQ];
    logic [31:0]       wdata_arr [NUM_REQ];

    assign any_req = |req_valid;

    // Unpack the flat address/data buses into per-requester words
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_arr[i]  = req_addr[32*i +: 32];
            wdata_arr[i] = req_wdata[32*i +: 32];
        end
    end

    // Round-robin search: first active requester after the last one served
    always_comb begin
        logic [ID_W-1:0] cand;
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(last_grant_q) + k) % NUM_REQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    // Next-state logic for the grant / issue / wait / respond sequence
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any_req) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (m_done) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register plus the latched grant, command and response data
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            grant_id     <= '0;
            m_addr       <= '0;
            m_wdata      <= '0;
            m_write_en   <= 1'b0;
            resp_rdata   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && win_found) begin
                grant_id   <= win_id;
                m_addr     <= addr_arr[win_id];
                m_wdata    <= wdata_arr[win_id];
                m_write_en <= req_write[win_id];
            end
            if (state_q == S_WAIT && m_done) begin
                resp_rdata   <= m_write_en ? 32'h0 : m_rdata;
                last_grant_q <= grant_id;
            end
        end
    end

    // State-decoded outputs: start pulse, busy flag and response pulse
    always_comb begin
        busy       = (state_q != S_IDLE);
        m_start    = (state_q == S_ISSUE);
        resp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            resp_valid[i] = (state_q == S_RESP) && (grant_id == ID_W'(i));
        end
    end

endmodule

// File: tb/tb_apb_request_arbiter.sv
// tb_apb_request_arbiter
// Drives the arbiter with directed scenarios and random requester traffic,
// emulates the APB master's start-to-done timing, and compares every output
// each cycle against a transaction-level reference model.
module tb_apb_request_arbiter;

    localparam int N  = 3;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*32-1:0]   req_addr;
    logic [N*32-1:0]   req_wdata;
    logic [N-1:0]      req_write;
    logic [N-1:0]      resp_valid;
    logic [31:0]       resp_rdata;
    logic              busy;
    logic [IW-1:0]     grant_id;
    logic [31:0]       m_addr;
    logic [31:0]       m_wdata;
    logic              m_write_en;
    logic              m_start;
    logic              m_done;
    logic [31:0]       m_rdata;

    apb_request_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_write(req_write), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .busy(busy), .grant_id(grant_id), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_write_en(m_write_en), .m_start(m_start), .m_done(m_done),
        .m_rdata(m_rdata)
    );

    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    // Reference model: one in-flight transaction described by its grant and
    // response cycle numbers, plus the round-robin pointer
    bit          act = 0;
    int          gcyc = 0;
    int          rcyc = -1;
    int          last_grant = N - 1;
    int          gid = 0;
    logic [31:0] e_addr = 0, e_wdata = 0, e_rdata = 0;
    bit          e_write = 0;

    // APB master emulation
    int          mcnt = 0;
    int          forced_wait = -1;
    bit          use_forced_rdata = 0;
    logic [31:0] forced_rdata = 0;
    logic [31:0] seen_addr, seen_wdata;
    logic        seen_write;

    // Observations for literal checks
    int          starts = 0, start_cycle = 0;
    int          resp_count = 0, resp_cycle_obs = 0, resp_id_obs = -1;
    logic [31:0] resp_data_obs;
    int          busy_count = 0;
    int          grants_obs[$];
    bit [N-1:0]  drop_next = '0;
    bit          hold_mode = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle=%0d got=%h expected=%h", name, cycle, got, exp);
        end
    endtask

    task automatic setReq(input int i, input logic [31:0] a, input logic [31:0] d, input logic w);
        req_valid[i]          = 1'b1;
        req_addr[32*i +: 32]  = a;
        req_wdata[32*i +: 32] = d;
        req_write[i]          = w;
    endtask

    task automatic modelUpdate();
        int cand;
        bit found;
        if (rst) begin
            act = 0; rcyc = -1; last_grant = N - 1; gid = 0;
            e_addr = 0; e_wdata = 0; e_write = 0; e_rdata = 0;
            return;
        end
        if (act) begin
            if (rcyc < 0 && cycle > gcyc && m_done === 1'b1) begin
                rcyc       = cycle + 1;
                e_rdata    = e_write ? 32'h0 : m_rdata;
                last_grant = gid;
            end else if (rcyc >= 0 && cycle == rcyc) begin
                act = 0;
            end
        end else if (req_valid != '0) begin
            found = 0;
            for (int k = 1; k <= N; k++) begin
                cand = (last_grant + k) % N;
                if (!found && req_valid[cand]) begin
                    found = 1;
                    gid   = cand;
                end
            end
            e_addr  = req_addr[32*gid +: 32];
            e_wdata = req_wdata[32*gid +: 32];
            e_write = req_write[gid];
            act = 1; gcyc = cycle + 1; rcyc = -1;
        end
    endtask

    task automatic checkOutput();
        logic [N-1:0] e_rv;
        e_rv = '0;
        if (act && rcyc >= 0 && cycle == rcyc) e_rv = N'(1) << gid;
        chk("busy",       32'(busy),       32'(act));
        chk("m_start",    32'(m_start),    32'(act && cycle == gcyc));
        chk("resp_valid", 32'(resp_valid), 32'(e_rv));
        chk("grant_id",   32'(grant_id),   32'(gid));
        chk("m_addr",     m_addr,          e_addr);
        chk("m_wdata",    m_wdata,         e_wdata);
        chk("m_write_en", 32'(m_write_en), 32'(e_write));
        chk("resp_rdata", resp_rdata,      e_rdata);
        if (m_start === 1'b1) begin
            starts++;
            start_cycle = cycle;
            grants_obs.push_back(int'(grant_id));
        end
        if (resp_valid != '0) begin
            resp_count++;
            resp_cycle_obs = cycle;
            resp_data_obs  = resp_rdata;
            for (int i = 0; i < N; i++) if (resp_valid[i]) resp_id_obs = i;
        end
        if (busy === 1'b1) busy_count++;
        drop_next = drop_next | e_rv;
    endtask

    task automatic masterDrive();
        int w;
        m_done  = 1'b0;
        m_rdata = $urandom;
        if (mcnt > 0) begin
            mcnt--;
            if (mcnt == 0) begin
                m_done = 1'b1;
                if (use_forced_rdata) m_rdata = forced_rdata;
            end
        end else if (m_start !== 1'b1 && $urandom_range(0, 7) == 0) begin
            m_done = 1'b1;
        end
        if (m_start === 1'b1) begin
            w          = (forced_wait >= 0) ? forced_wait : int'($urandom_range(0, 3));
            mcnt       = 3 + w;
            seen_addr  = m_addr;
            seen_wdata = m_wdata;
            seen_write = m_write_en;
        end
    endtask

    task automatic autoDrop();
        if (!hold_mode) req_valid = req_valid & ~drop_next;
        drop_next = '0;
    endtask

    task automatic stepCycle();
        modelUpdate();
        @(posedge clk);
        #1;
        cycle++;
        autoDrop();
        checkOutput();
        masterDrive();
    endtask

    task automatic waitResp(input int maxc, input string name);
        int r0;
        bit got;
        r0  = resp_count;
        got = 0;
        for (int k = 0; k < maxc && !got; k++) begin
            stepCycle();
            if (resp_count != r0) got = 1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("[TB] FAIL %s got=no_response expected=response_within_%0d_cycles", name, maxc);
        end
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && !drop_next[i] && !(act && gid == i)) begin
                if ($urandom_range(0, 2) == 0)
                    setReq(i, $urandom, $urandom, 1'($urandom_range(0, 1)));
            end else if (req_valid[i]) begin
                if (act && gid == i && cycle > gcyc && $urandom_range(0, 15) == 0)
                    req_valid[i] = 1'b0;
                else if ($urandom_range(0, 7) == 0)
                    req_addr[32*i +: 32] = $urandom;
            end
        end
    endtask

    int c0, s0, r0;

    // Directed scenarios followed by random traffic
    initial begin
        rst = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        m_done = 1'b0; m_rdata = '0;
        stepCycle();
        stepCycle();
        rst = 1'b0;
        stepCycle();

        $display("[TB] single read from requester 0");
        forced_wait = 0; use_forced_rdata = 1; forced_rdata = 32'hDEAD_BEEF;
        setReq(0, 32'h0000_0010, 32'h0, 1'b0);
        c0 = cycle; s0 = starts; busy_count = 0;
        waitResp(20, "t1_resp");
        stepCycle();
        chk("t1_start_cycle", 32'(start_cycle - c0), 32'd1);
        chk("t1_resp_cycle",  32'(resp_cycle_obs - c0), 32'd5);
        chk("t1_rdata",       resp_data_obs, 32'hDEAD_BEEF);
        chk("t1_resp_id",     32'(resp_id_obs), 32'd0);
        chk("t1_starts",      32'(starts - s0), 32'd1);
        chk("t1_busy_cycles", 32'(busy_count), 32'd5);

        $display("[TB] single write from requester 1");
        setReq(1, 32'h0000_0020, 32'h1234_5678, 1'b1);
        waitResp(20, "t2_resp");
        stepCycle();
        chk("t2_pwdata",  seen_wdata, 32'h1234_5678);
        chk("t2_pwrite",  32'(seen_write), 32'd1);
        chk("t2_paddr",   seen_addr, 32'h0000_0020);
        chk("t2_rdata",   resp_data_obs, 32'h0);
        chk("t2_resp_id", 32'(resp_id_obs), 32'd1);

        $display("[TB] requesters 0 and 1 held continuously");
        use_forced_rdata = 0; hold_mode = 1;
        grants_obs.delete();
        setReq(0, 32'h100, 32'h1, 1'b0);
        setReq(1, 32'h104, 32'h2, 1'b1);
        repeat (24) stepCycle();
        chk("t3_grant_count", 32'(grants_obs.size()), 32'd4);
        for (int k = 0; k < 4; k++)
            chk("t3_grant_order", (k < grants_obs.size()) ? 32'(grants_obs[k]) : 32'hFFFF_FFFF, 32'(k % 2));
        req_valid = '0; hold_mode = 0;
        repeat (10) stepCycle();

        $display("[TB] read with three wait states");
        forced_wait = 3;
        setReq(2, 32'h0000_0030, 32'h0, 1'b0);
        c0 = cycle; s0 = starts;
        waitResp(30, "t4_resp");
        stepCycle();
        chk("t4_resp_cycle", 32'(resp_cycle_obs - c0), 32'd8);
        chk("t4_starts",     32'(starts - s0), 32'd1);
        chk("t4_paddr",      seen_addr, 32'h0000_0030);
        chk("t4_resp_id",    32'(resp_id_obs), 32'd2);

        $display("[TB] address change and request drop after grant");
        forced_wait = 1;
        setReq(0, 32'h0000_0040, 32'h55, 1'b1);
        s0 = starts; r0 = resp_count;
        stepCycle();
        stepCycle();
        req_addr[31:0] = 32'h0000_0099;
        req_valid[0]   = 1'b0;
        waitResp(20, "t5_resp");
        repeat (8) stepCycle();
        chk("t5_paddr",   seen_addr, 32'h0000_0040);
        chk("t5_m_addr",  m_addr, 32'h0000_0040);
        chk("t5_starts",  32'(starts - s0), 32'd1);
        chk("t5_resps",   32'(resp_count - r0), 32'd1);
        chk("t5_resp_id", 32'(resp_id_obs), 32'd0);

        $display("[TB] reset while waiting for done");
        forced_wait = 2;
        setReq(1, 32'h0000_0050, 32'h0, 1'b0);
        repeat (3) stepCycle();
        rst = 1'b1; req_valid = '0;
        r0 = resp_count;
        stepCycle();
        rst = 1'b0;
        repeat (8) stepCycle();
        chk("t6_no_resp", 32'(resp_count - r0), 32'd0);
        chk("t6_m_addr",  m_addr, 32'h0);
        chk("t6_busy",    32'(busy), 32'd0);
        grants_obs.delete();
        setReq(0, 32'h60, 32'h0, 1'b0);
        setReq(1, 32'h64, 32'h0, 1'b0);
        waitResp(20, "t6_first_resp");
        waitResp(20, "t6_second_resp");
        repeat (3) stepCycle();
        chk("t6_first_grant", (grants_obs.size() > 0) ? 32'(grants_obs[0]) : 32'hFFFF_FFFF, 32'd0);

        $display("[TB] random traffic");
        forced_wait = -1;
        repeat (600) begin
            applyStimulus();
            stepCycle();
        end
        req_valid = '0;
        repeat (15) stepCycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_request_arbiter.md
# apb_request_arbiter

Round-robin arbiter that shares the single APB master interface among NUM_REQ command sources (e.g. UART command decoder, on-chip test sequencer). It accepts one held request per source, issues exactly one single-cycle start to the APB master per transaction, waits for its done, and returns read data and a one-cycle response pulse to the winning source. It sits between the requesters and the APB master interface.

## Interface
- NUM_REQ, 2, number of requesters; legal range 2..8
- ID_W, $clog2(NUM_REQ), width of the requester index
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request; held high until that requester's resp_valid
- req_addr  in  NUM_REQ*32  packed addresses; requester i at [32*i +: 32]
- req_wdata  in  NUM_REQ*32  packed write data, same packing
- req_write  in  NUM_REQ  1 = write, 0 = read
- resp_valid  out  NUM_REQ  one-cycle completion pulse to the served requester
- resp_rdata  out  32  read data for the current resp_valid; 0 after writes
- busy  out  1  high from grant until the end of the response cycle
- grant_id  out  ID_W  index of the requester being served; valid while busy
- m_addr  out  32  to APB master addr
- m_wdata  out  32  to APB master wdata
- m_write_en  out  1  to APB master write_en
- m_start  out  1  to APB master start; exactly one cycle per transaction
- m_done  in  1  from APB master done
- m_rdata  in  32  from APB master rdata

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid, pick the winner by round-robin starting at last_grant+1 (mod NUM_REQ) and searching upward. Latch its addr, wdata, and write into m_addr, m_wdata, and m_write_en. Set grant_id and busy=1, then go to ISSUE. With no request, stay in IDLE.
- ISSUE: m_start=1 for this cycle only; go to WAIT.
- WAIT: m_start=0. On m_done=1, capture resp_rdata = m_write_en ? 0 : m_rdata, set last_grant = grant_id, and go to RESP. No timeout; wait indefinitely.
- RESP: resp_valid[grant_id]=1 for this cycle only; go to IDLE with busy=0. Requests are not sampled in RESP, so a requester that drops req_valid on the edge after resp_valid is never double-served.
- m_addr, m_wdata, m_write_en, and grant_id stay stable from the grant edge until the next grant.
- Requester changes to addr/wdata/write after the grant are ignored for the current transaction.
- If req_valid drops mid-transaction, the transaction still completes and the response pulse is still issued.
- m_done seen outside WAIT is ignored.
- Fairness: a requester holding req_valid is served within NUM_REQ transactions.
- Reset values: state=IDLE, last_grant=NUM_REQ-1 (so requester 0 wins first), all outputs 0.
- Reset mid-transaction: the transaction is abandoned with no response. A late m_done after reset is ignored because the arbiter is in IDLE. System reset must cover the APB master's in-flight transfer; integration holds rst until the master's done has pulsed or it is idle.

## Timing
- Cycle 0: req_valid is sampled high in IDLE. Edge 1: ISSUE, with m_start high during cycle 1.
- The APB master enters SETUP at edge 2 and ACCESS at edge 3.
- With PREADY=1 in ACCESS, the master's done is high during cycle 4. The arbiter enters RESP at edge 5, with resp_valid high during cycle 5.
- Minimum request-to-response latency: 5 cycles. Each PREADY wait state adds 1 cycle.
- Back-to-back: IDLE is re-entered at edge 6, and the next grant can be sampled in cycle 6. Minimum spacing is 6 cycles per transaction.
- Simultaneous requests are resolved in the same IDLE cycle; the winner is a pure function of req_valid and last_grant.

## Test plan
- Single read, requester 0, addr 0x0000_0010, PRDATA 0xDEAD_BEEF, PREADY=1 → m_start pulses once in cycle 1; resp_valid[0] in cycle 5 with resp_rdata 0xDEAD_BEEF; busy high cycles 1–5.
- Single write, requester 1, addr 0x20, wdata 0x1234_5678 → PWDATA 0x1234_5678 with PWRITE=1; resp_valid[1] with resp_rdata 0.
- Both requesters held continuously, NUM_REQ=2 → grant order 0,1,0,1; each resp_valid is exactly one cycle; no transaction is issued twice.
- PREADY low for 3 cycles in ACCESS → resp_valid arrives in cycle 8; m_addr is unchanged throughout; m_start pulses once.
- req_addr changed after the grant and req_valid dropped in WAIT → the original address is used, the response is still pulsed, and no new grant occurs.
- rst asserted during WAIT, master done arriving afterward → no resp_valid; all outputs 0; the next request is served normally starting from requester 0.
